// File: rtl/mul_pkg.sv
// Shared definitions for the Barrett multiplier datapath: default widths,
// the iterative multiplier FSM state type and the tile-count helper.
package mul_pkg;

  localparam int MUL_SIZE_DEF = 56;
  localparam int RADIX_DEF    = 54;
  localparam int TILE_DEF     = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  function automatic int tile_count(input int width, input int tile);
    return (width + tile - 1) / tile;
  endfunction

endpackage

// File: rtl/mul_tile_dsp.sv
// Unsigned TILE x TILE multiply, sized to land in a single DSP slice.
module mul_tile_dsp #(
  parameter int TILE = 18
) (
  input  logic [TILE-1:0]   x,
  input  logic [TILE-1:0]   y,
  output logic [2*TILE-1:0] p
);

  assign p = x * y;

endmodule

// File: rtl/multiplier_tiled_iter.sv
// Iterative tiled multiplier: one tile multiplier reused for NT*NT cycles,
// shifted partial products accumulated into a full-width product.
module multiplier_tiled_iter
  import mul_pkg::*;
#(
  parameter int MUL_SIZE = MUL_SIZE_DEF,
  parameter int RADIX    = RADIX_DEF,
  parameter int TILE     = TILE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MUL_SIZE-1:0]   a,
  input  logic [MUL_SIZE-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*MUL_SIZE-1:0] prod,
  output logic [1:0]            res_upper,
  output logic [RADIX-1:0]      res_mid
);

  localparam int NT     = tile_count(MUL_SIZE, TILE);
  localparam int EXT_W  = NT * TILE;
  localparam int PROD_W = 2 * MUL_SIZE;
  localparam int IW     = (NT > 1) ? $clog2(NT) : 1;
  localparam logic [IW-1:0] LAST = IW'(NT - 1);

  generate
    if (RADIX > MUL_SIZE - 2) begin : g_bad_radix
      $error("multiplier_tiled_iter: RADIX must not exceed MUL_SIZE-2");
    end
  endgenerate

  mul_state_t        state;
  logic [EXT_W-1:0]  a_reg, b_reg;
  logic [PROD_W-1:0] acc, prod_reg;
  logic [IW-1:0]     i_reg, j_reg;
  logic              out_valid_reg;

  logic [TILE-1:0] a_tiles [NT];
  logic [TILE-1:0] b_tiles [NT];

  genvar gi;
  generate
    for (gi = 0; gi < NT; gi++) begin : g_tiles
      assign a_tiles[gi] = a_reg[gi*TILE +: TILE];
      assign b_tiles[gi] = b_reg[gi*TILE +: TILE];
    end
  endgenerate

  logic [TILE-1:0]   tile_a, tile_b;
  logic [2*TILE-1:0] tile_p;
  logic [PROD_W-1:0] pp_shifted, acc_next;

  assign tile_a = a_tiles[i_reg];
  assign tile_b = b_tiles[j_reg];

  mul_tile_dsp #(.TILE(TILE)) u_tile_dsp (
    .x(tile_a),
    .y(tile_b),
    .p(tile_p)
  );

  // Each shifted partial product is bounded by a*b, so keeping only the low
  // PROD_W bits never drops a set bit.
  assign pp_shifted = PROD_W'(tile_p) << (TILE * (32'(i_reg) + 32'(j_reg)));
  assign acc_next   = acc + pp_shifted;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = out_valid_reg;
  assign prod      = prod_reg;
  assign res_upper = prod_reg[2*RADIX+3 -: 2];
  assign res_mid   = prod_reg[2*RADIX-1 -: RADIX];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      acc           <= '0;
      prod_reg      <= '0;
      i_reg         <= '0;
      j_reg         <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= EXT_W'(a);
            b_reg <= EXT_W'(b);
            acc   <= '0;
            i_reg <= '0;
            j_reg <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          if (j_reg == LAST) begin
            j_reg <= '0;
            if (i_reg == LAST) begin
              i_reg         <= '0;
              prod_reg      <= acc_next;
              out_valid_reg <= 1'b1;
              state         <= DONE;
            end else begin
              i_reg <= i_reg + 1'b1;
            end
          end else begin
            j_reg <= j_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            if (in_valid) begin
              a_reg <= EXT_W'(a);
              b_reg <= EXT_W'(b);
              acc   <= '0;
              i_reg <= '0;
              j_reg <= '0;
              state <= MAC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_tiled_iter.sv
// Directed and table-driven checks for the iterative tiled multiplier,
// default 56-bit configuration plus a 34-bit (NT=2) instance.
module tb_multiplier_tiled_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, out_ready = 1'b0;
  logic         in_ready, out_valid;
  logic [55:0]  a = '0, b = '0;
  logic [111:0] prod;
  logic [1:0]   res_upper;
  logic [53:0]  res_mid;

  multiplier_tiled_iter #(.MUL_SIZE(56), .RADIX(54), .TILE(18)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .prod(prod), .res_upper(res_upper), .res_mid(res_mid)
  );

  logic        s_in_valid = 1'b0, s_out_ready = 1'b0;
  logic        s_in_ready, s_out_valid;
  logic [33:0] s_a = '0, s_b = '0;
  logic [67:0] s_prod;
  logic [1:0]  s_res_upper;
  logic [31:0] s_res_mid;

  multiplier_tiled_iter #(.MUL_SIZE(34), .RADIX(32), .TILE(18)) dut34 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .prod(s_prod), .res_upper(s_res_upper), .res_mid(s_res_mid)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic issue(input logic [55:0] x, input logic [55:0] y);
    @(negedge clk);
    a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [55:0]  va;
    logic [55:0]  vb;
    logic [111:0] eprod;
    logic [1:0]   eupper;
    logic [53:0]  emid;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int cyc, got, issued, last, n;
    logic [111:0] e, held;
    logic [55:0]  pa [8];
    logic [55:0]  pb [8];
    logic [33:0]  x34, y34;
    logic [67:0]  e34;

    vecs[0] = '{56'hFF_FFFF_FFFF_FFFF, 56'hFF_FFFF_FFFF_FFFF,
                112'hFFFF_FFFF_FFFF_FE00_0000_0000_0001, 2'b11, 54'h3F_FFFF_FFFF_FFF8};
    vecs[1] = '{56'h80_0000_0000_0000, 56'h80_0000_0000_0000,
                112'h4000_0000_0000_0000_0000_0000_0000, 2'b01, 54'h0};
    vecs[2] = '{56'd3, 56'd5, 112'd15, 2'b00, 54'h0};
    vecs[3] = '{56'd0, 56'hFF_FFFF_FFFF_FFFF, 112'd0, 2'b00, 54'h0};

    // Reset state
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_prod", prod, 0);
    chk("rst_res_upper", res_upper, 0);
    chk("rst_res_mid", res_mid, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors
    for (int k = 0; k < 4; k++) begin
      issue(vecs[k].va, vecs[k].vb);
      wait_valid(cyc);
      chk($sformatf("vec%0d_latency", k), cyc, 16);
      chk($sformatf("vec%0d_prod", k), prod, vecs[k].eprod);
      chk($sformatf("vec%0d_res_upper", k), res_upper, vecs[k].eupper);
      chk($sformatf("vec%0d_res_mid", k), res_mid, vecs[k].emid);
      pop();
      chk($sformatf("vec%0d_popped", k), out_valid, 0);
      $display("vec%0d a=%0h b=%0h prod=%0h", k, vecs[k].va, vecs[k].vb, prod);
    end

    // Backpressure, then pop and push in the same cycle
    issue(56'h12_3456_789A_BCDE, 56'hFE_DCBA_9876_5432);
    e = 112'(56'h12_3456_789A_BCDE) * 112'(56'hFE_DCBA_9876_5432);
    wait_valid(cyc);
    chk("bp_prod", prod, e);
    held = prod;
    for (int k = 0; k < 10; k++) begin
      a = 56'd9; b = 56'd9; in_valid = 1'b1;
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold", prod, held);
    end
    a = 56'd3; b = 56'd7; out_ready = 1'b1;
    #1;
    chk("bp_in_ready_pop", in_ready, 1);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    chk("pushpop_out_valid", out_valid, 0);
    wait_valid(cyc);
    chk("pushpop_latency", cyc, 16);
    chk("pushpop_prod", prod, 21);
    $display("backpressure prod=%0h then push 3x7 prod=%0h", held, prod);
    pop();

    // Back-to-back stream
    for (int k = 0; k < 8; k++) begin
      pa[k] = {$urandom_range(16777215), $urandom};
      pb[k] = {$urandom_range(16777215), $urandom};
    end
    pa[0] = 56'hFF_FFFF_FFFF_FFFF;
    got = 0; issued = 0; last = 0; cyc = 0;
    out_ready = 1'b1;
    while (got < 8 && cyc < 400) begin
      if (out_valid) begin
        e = 112'(pa[got]) * 112'(pb[got]);
        chk($sformatf("b2b%0d_prod", got), prod, e);
        if (got > 0) chk($sformatf("b2b%0d_gap", got), cyc - last, 17);
        $display("b2b%0d a=%0h b=%0h prod=%0h cycle=%0d", got, pa[got], pb[got], prod, cyc);
        last = cyc;
        got++;
      end
      if (issued < 8 && in_ready) begin
        a = pa[issued]; b = pb[issued]; in_valid = 1'b1;
        issued++;
      end else if (issued == 8) begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    chk("b2b_count", got, 8);
    out_ready = 1'b0; in_valid = 1'b0;

    // Reset five cycles into MAC
    issue(56'hFF_FFFF_FFFF_FFFF, 56'h12_3456);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_mac_out_valid", out_valid, 0);
    chk("abort_mac_in_ready", in_ready, 1);
    chk("abort_mac_prod", prod, 0);
    @(negedge clk);
    rst = 1'b0;
    issue(56'd7, 56'd9);
    wait_valid(cyc);
    chk("after_abort_latency", cyc, 16);
    chk("after_abort_prod", prod, 63);
    $display("after abort 7x9 prod=%0h", prod);

    // Reset while a result is presented
    #2 rst = 1'b1;
    #1;
    chk("abort_done_out_valid", out_valid, 0);
    chk("abort_done_prod", prod, 0);
    @(negedge clk);
    rst = 1'b0;

    // 34-bit instance, NT=2
    for (int k = 0; k < 1000; k++) begin
      if (k == 0) begin
        x34 = '1; y34 = '1;
      end else begin
        x34 = {2'($urandom_range(3)), $urandom};
        y34 = {2'($urandom_range(3)), $urandom};
      end
      e34 = 68'(x34) * 68'(y34);
      @(negedge clk);
      s_a = x34; s_b = y34; s_in_valid = 1'b1;
      @(negedge clk);
      s_in_valid = 1'b0;
      n = 0;
      while (!s_out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (k == 0) chk("sweep_latency", n, 4);
      chk($sformatf("sweep%0d_prod", k), s_prod, e34);
      chk($sformatf("sweep%0d_res_upper", k), s_res_upper, e34[67:66]);
      chk($sformatf("sweep%0d_res_mid", k), s_res_mid, e34[63:32]);
      if (k < 4) $display("sweep%0d a=%0h b=%0h prod=%0h", k, x34, y34, s_prod);
      s_out_ready = 1'b1;
      @(negedge clk);
      s_out_ready = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multiplier_tiled_iter.md
# multiplier_tiled_iter

Parametrised, iterative tiled multiplier for the Barrett-reduction datapath. It forms the full `MUL_SIZE`×`MUL_SIZE` product by reusing one DSP-sized tile multiplier over successive cycles, accumulating shifted partial products. It presents the full product plus the two reduction slices (upper-2-bit and middle) behind valid/ready handshakes. It replaces the fixed 56-bit, nine-DSP combinational multipliers where DSP count matters more than throughput.

## Interface
Parameters:
- `MUL_SIZE`, 56: operand width in bits.
- `RADIX`, 54: Barrett radix. Constraint: `RADIX <= MUL_SIZE-2`, checked at elaboration.
- `TILE`, 18: tile width, matching the DSP multiplier input.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `in_valid`, in, 1: the operand pair is valid.
- `in_ready`, out, 1: the block can accept operands.
- `a`, in, `MUL_SIZE`: multiplicand.
- `b`, in, `MUL_SIZE`: multiplier.
- `out_valid`, out, 1: results are valid.
- `out_ready`, in, 1: the consumer accepts the results.
- `prod`, out, `2*MUL_SIZE`: full product a×b.
- `res_upper`, out, 2: `prod[2*RADIX+3:2*RADIX+2]`.
- `res_mid`, out, `RADIX`: `prod[2*RADIX-1:RADIX]`.

## Operation
- Tile count `NT = ceil(MUL_SIZE/TILE)`. Operands are zero-extended to `NT*TILE` and split into tiles `a_t[i]` and `b_t[j]`.
- State machine with states IDLE, MAC and DONE.
  - IDLE: `in_ready=1`. When `in_valid` is high: register `a` and `b`, clear `acc`, set `i=j=0`, go to MAC.
  - MAC: each cycle `acc += (a_t[i]*b_t[j]) << (TILE*(i+j))`. `j` increments first; on wrap `j=0` and `i++`. After the step with `i=j=NT-1`, go to DONE.
  - DONE: `out_valid=1`. `prod`, `res_upper` and `res_mid` are driven from `acc` and held stable while `out_ready=0`. When `out_ready=1`, either go to IDLE, or go to MAC if a new operand is accepted in the same cycle.
- `in_ready = (state==IDLE) | (state==DONE & out_ready)`. This combinational path allows back-to-back operation.
- In MAC, `in_valid` is ignored and `a`/`b` may change freely.
- `acc` is `2*MUL_SIZE` bits. Every partial product fits, so the sum cannot overflow and no truncation occurs.

## Timing
- Reset values (async assert): state=IDLE, `acc=0`, `i=j=0`, `out_valid=0`, `in_ready=1` (combinational from IDLE), `prod=0`, `res_upper=0`, `res_mid=0`.
- Reset deassertion takes effect at the next `clk` edge.
- Latency: operand accepted at edge E0 → `out_valid` high after edge E0+`NT²`. With the defaults this is 16 MAC cycles.
- Throughput with `out_ready` held high: one result every `NT²+1` cycles. This is 17 for the defaults.
- Reset mid-MAC or mid-DONE aborts immediately. No partial result is ever presented; `out_valid` drops asynchronously.
- If `out_ready=1` and `in_valid=1` in DONE, the pop and the push happen in the same cycle. The old result is consumed and the new operands are latched.
- `out_ready` outside DONE has no effect.

## Structure
- Shared package `mul_pkg`:
  - function `tile_count(width, tile)`;
  - FSM state enum `mul_state_t` (IDLE/MAC/DONE);
  - defaults for `MUL_SIZE`, `RADIX` and `TILE`, also reused by the Barrett top.
- One sub-module, `mul_tile_dsp`: a purely combinational `TILE`×`TILE` → `2*TILE` unsigned multiply that maps to one DSP slice.
- The tile select, shift and accumulate logic lives in the top module.

## Test plan
- `a=b=2^56-1`, `out_ready=1` → after 16 cycles:
  - `prod = 2^112-2^57+1`;
  - `res_upper = 2'b11`;
  - `res_mid = 0x3FFFFFFFFFFFF8`.
- `a=b=2^55` → `prod=2^110`, `res_upper=2'b01`, `res_mid=0`. Then `a=3`, `b=5` → `prod=15`, `res_upper=0`, `res_mid=0`. Then `a=0`, `b=2^56-1` → `prod=0`.
- Backpressure: hold `out_ready=0` for 10 cycles after `out_valid` rises. Required response:
  - outputs stay stable;
  - `in_ready=0`;
  - a new `in_valid` is not accepted until `out_ready` rises.
- Back-to-back: 8 random operand pairs with `in_valid` and `out_ready` held high → results match a reference model, in order, exactly 17 cycles apart.
- Assert `rst` 5 cycles into MAC → `out_valid=0` and `in_ready=1` immediately. The next operation, 7×9, returns 63 with no residue from the aborted one.
- Parameter sweep `MUL_SIZE=34`, `RADIX=32`, `TILE=18` (NT=2, 4 MAC cycles): 1000 random vectors match a reference model.
